// File: rtl/basic_op_server.sv
// Shared G.729 basic-op responder: round-robin arbiter feeding a 3-stage L_mult/mult/L_mac pipeline.
// Define BASIC_OP_MSU_EN to serve opcode 11 as L_msu; otherwise it completes with result 0.
module basic_op_server #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [2*NUM_REQ-1:0]  op,
  input  logic [16*NUM_REQ-1:0] var_a,
  input  logic [16*NUM_REQ-1:0] var_b,
  input  logic [32*NUM_REQ-1:0] acc_c,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic [31:0]           result,
  output logic                  overflow
);

  localparam logic [1:0]           OP_LMULT = 2'b00;
  localparam logic [1:0]           OP_MULT  = 2'b01;
  localparam logic [1:0]           OP_LMAC  = 2'b10;
  localparam logic [PTR_W:0]       NREQ     = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0]     LAST     = PTR_W'(NUM_REQ-1);
  // Only 0x8000*0x8000 produces this product; it is the sole L_mult/mult overflow case.
  localparam logic signed [31:0]   P_MIN_SQ = 32'sh4000_0000;

  // All arithmetic helpers return {overflow, value}.
  function automatic logic [32:0] sat32(input logic signed [32:0] s);
    if (s[32] != s[31]) return {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    return {1'b0, s[31:0]};
  endfunction

  function automatic logic [32:0] sat16(input logic signed [31:0] t);
    if (t > 32'sd32767)  return {1'b1, 32'h0000_7FFF};
    if (t < -32'sd32768) return {1'b1, 32'hFFFF_8000};
    return {1'b0, {16{t[15]}}, t[15:0]};
  endfunction

  function automatic logic [32:0] l_mult(input logic signed [31:0] p);
    if (p == P_MIN_SQ) return {1'b1, 32'h7FFF_FFFF};
    return {1'b0, p[30:0], 1'b0};
  endfunction

  function automatic logic [32:0] mult_r(input logic signed [31:0] p);
    return sat16(p >>> 15);
  endfunction

  function automatic logic [32:0] l_add(input logic signed [31:0] x, input logic signed [31:0] y);
    return sat32(33'(x) + 33'(y));
  endfunction

`ifdef BASIC_OP_MSU_EN
  localparam logic [1:0] OP_LMSU = 2'b11;

  function automatic logic [32:0] l_sub(input logic signed [31:0] x, input logic signed [31:0] y);
    return sat32(33'(x) - 33'(y));
  endfunction
`endif

  logic [PTR_W-1:0]    ptr_q, ptr_d, gnt_id;
  logic [PTR_W:0]      idx_w;
  logic                gnt_any;
  logic [NUM_REQ-1:0]  gnt_d;

  logic                vld_p1_q, vld_p2_q;
  logic [1:0]          op_p1_q, op_p2_q;
  logic signed [15:0]  a_p1_q, b_p1_q;
  logic signed [31:0]  c_p1_q, c_p2_q;
  logic [PTR_W-1:0]    id_p1_q, id_p2_q;
  logic signed [31:0]  p_p2_q;

  logic [32:0]         lm_p2;
  logic [31:0]         res_d, result_q;
  logic                ovf_d, ovf_q;
  logic [NUM_REQ-1:0]  done_d, done_q;

  always_comb begin
    gnt_d   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx_w   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_w = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (idx_w >= NREQ) idx_w = idx_w - NREQ;
      if (!gnt_any && req[idx_w[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx_w[PTR_W-1:0];
      end
    end
    if (!reset) gnt_any = 1'b0;
    if (gnt_any) gnt_d[gnt_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (gnt_id == LAST) ? '0 : gnt_id + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      done_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      vld_p1_q <= gnt_any;
      vld_p2_q <= vld_p1_q;
      done_q   <= done_d;
      if (vld_p2_q) begin
        result_q <= res_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  // Stage 1: capture the granted client's opcode and operands
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      op_p1_q <= op[2*gnt_id +: 2];
      a_p1_q  <= var_a[16*gnt_id +: 16];
      b_p1_q  <= var_b[16*gnt_id +: 16];
      c_p1_q  <= acc_c[32*gnt_id +: 32];
      id_p1_q <= gnt_id;
    end
  end

  // Stage 2: signed 16x16 product
  always_ff @(posedge clk) begin
    if (vld_p1_q) begin
      p_p2_q  <= 32'(a_p1_q) * 32'(b_p1_q);
      op_p2_q <= op_p1_q;
      c_p2_q  <= c_p1_q;
      id_p2_q <= id_p1_q;
    end
  end

  // Stage 3: op-specific shift / saturate / accumulate
  always_comb begin
    lm_p2  = l_mult(p_p2_q);
    res_d  = '0;
    ovf_d  = 1'b0;
    done_d = '0;
    case (op_p2_q)
      OP_LMULT: {ovf_d, res_d} = lm_p2;
      OP_MULT:  {ovf_d, res_d} = mult_r(p_p2_q);
      OP_LMAC: begin
        {ovf_d, res_d} = l_add(c_p2_q, lm_p2[31:0]);
        ovf_d = ovf_d | lm_p2[32];
      end
`ifdef BASIC_OP_MSU_EN
      OP_LMSU: begin
        {ovf_d, res_d} = l_sub(c_p2_q, lm_p2[31:0]);
        ovf_d = ovf_d | lm_p2[32];
      end
`endif
      default: begin
        res_d = '0;
        ovf_d = 1'b0;
      end
    endcase
    if (vld_p2_q) done_d[id_p2_q] = 1'b1;
  end

  assign gnt      = gnt_d;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_basic_op_server.sv
// Directed bench for basic_op_server: vector table through single clients, plus
// round-robin streaming and mid-flight reset sequences.
`timescale 1ns/1ps
module tb_basic_op_server;

  localparam int NUM_REQ = 4;
  localparam int NVEC    = 10;

  logic                  clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [2*NUM_REQ-1:0]  op;
  logic [16*NUM_REQ-1:0] var_a;
  logic [16*NUM_REQ-1:0] var_b;
  logic [32*NUM_REQ-1:0] acc_c;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           result;
  logic                  overflow;

  basic_op_server #(.NUM_REQ(NUM_REQ), .PTR_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .op       (op),
    .var_a    (var_a),
    .var_b    (var_b),
    .acc_c    (acc_c),
    .gnt      (gnt),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [31:0] rr_res [4];
  logic        rr_ovf [4];
  int          n_pass;
  int          n_total;
  int          cl;
  int          j;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input int c, input logic [1:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] acc);
    op[2*c +: 2]     = o;
    var_a[16*c +: 16] = a;
    var_b[16*c +: 16] = b;
    acc_c[32*c +: 32] = acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{2'b00, 16'h4000, 16'h4000, 32'h0000_0000, 32'h2000_0000, 1'b0};
    vecs[1] = '{2'b00, 16'h8000, 16'h8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[2] = '{2'b01, 16'h8000, 16'h8000, 32'h0000_0000, 32'h0000_7FFF, 1'b1};
    vecs[3] = '{2'b01, 16'h4000, 16'h4000, 32'h0000_0000, 32'h0000_2000, 1'b0};
    vecs[4] = '{2'b10, 16'h0100, 16'h0100, 32'h7FFF_FFF0, 32'h7FFF_FFFF, 1'b1};
    vecs[5] = '{2'b10, 16'h0100, 16'h0100, 32'h0000_0010, 32'h0002_0010, 1'b0};
`ifdef BASIC_OP_MSU_EN
    vecs[6] = '{2'b11, 16'h4000, 16'h4000, 32'h0000_0000, 32'hE000_0000, 1'b0};
`else
    vecs[6] = '{2'b11, 16'h4000, 16'h4000, 32'h0000_0000, 32'h0000_0000, 1'b0};
`endif
    vecs[7] = '{2'b01, 16'hC000, 16'h4000, 32'h0000_0000, 32'hFFFF_E000, 1'b0};
    vecs[8] = '{2'b10, 16'h8000, 16'h0001, 32'h8000_0000, 32'h8000_0000, 1'b1};
    vecs[9] = '{2'b10, 16'h8000, 16'h8000, 32'hFFFF_FFFF, 32'h7FFF_FFFE, 1'b1};

    rr_res[0] = 32'h2000_0000; rr_ovf[0] = 1'b0;
    rr_res[1] = 32'h0000_2000; rr_ovf[1] = 1'b0;
    rr_res[2] = 32'h0002_0010; rr_ovf[2] = 1'b0;
    rr_res[3] = 32'h7FFF_FFFF; rr_ovf[3] = 1'b1;

    // Reset state, with every client requesting
    reset = 1'b0;
    req   = '1;
    op    = '0;
    var_a = '0;
    var_b = '0;
    acc_c = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    req   = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin: all clients held high, back-to-back grants
    drive(0, 2'b00, 16'h4000, 16'h4000, 32'h0);
    drive(1, 2'b01, 16'h4000, 16'h4000, 32'h0);
    drive(2, 2'b10, 16'h0100, 16'h0100, 32'h0000_0010);
    drive(3, 2'b00, 16'h8000, 16'h8000, 32'h0);
    req = 4'hF;
    for (int k = 0; k < 11; k++) begin
      if (k == 8) req = '0;
      @(negedge clk);
      if (k < 8) chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(4'(1) << (k % 4)));
      else       chk($sformatf("rr%0d_gnt", k), 32'(gnt), 32'h0);
      if (k >= 3) begin
        j = (k - 3) % 4;
        chk($sformatf("rr%0d_done", k), 32'(done), 32'(4'(1) << j));
        chk($sformatf("rr%0d_result", k), result, rr_res[j]);
        chk($sformatf("rr%0d_ovf", k), 32'(overflow), 32'(rr_ovf[j]));
      end else begin
        chk($sformatf("rr%0d_done", k), 32'(done), 32'h0);
      end
      @(posedge clk);
      #1;
    end

    // Table vectors, each through a single client
    for (int k = 0; k < NVEC; k++) begin
      cl = k % 4;
      drive(cl, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].c);
      req = 4'(1) << cl;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", k), 32'(gnt), 32'(4'(1) << cl));
      @(posedge clk);
      #1;
      req = '0;
      @(negedge clk);
      chk($sformatf("vec%0d_done_n1", k), 32'(done), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_done_n2", k), 32'(done), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_done", k), 32'(done), 32'(4'(1) << cl));
      chk($sformatf("vec%0d_result", k), result, vecs[k].res);
      chk($sformatf("vec%0d_ovf", k), 32'(overflow), 32'(vecs[k].ovf));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_done_n4", k), 32'(done), 32'h0);
      chk($sformatf("vec%0d_hold", k), result, vecs[k].res);
      @(posedge clk);
      #1;
    end

    // Reset with three operations in flight
    for (int k = 0; k < 4; k++) drive(k, 2'b00, 16'h4000, 16'h4000, 32'h0);
    req = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("prerst_done_any", 32'(done != '0), 32'h1);
    reset = 1'b0;
    req   = 4'b1010;
    drive(1, 2'b00, 16'h0003, 16'h0005, 32'h0);
    #1;
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_ovf", 32'(overflow), 32'h0);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_gnt", 32'(gnt), 32'h2);
    @(posedge clk);
    #1;
    req = '0;
    for (int r = 1; r <= 5; r++) begin
      @(negedge clk);
      if (r == 3) begin
        chk("postrst_done", 32'(done), 32'h2);
        chk("postrst_result", result, 32'h0000_001E);
        chk("postrst_ovf", 32'(overflow), 32'h0);
      end else begin
        chk($sformatf("postrst%0d_nodone", r), 32'(done), 32'h0);
        if (r < 3) chk($sformatf("postrst%0d_result", r), result, 32'h0);
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/basic_op_server.md
Name: basic_op_server

Overview:
- Shared responder for the G.729 basic-op multiply/accumulate interface.
- Owns a single pipelined L_mult / mult / L_mac datapath and serves up to NUM_REQ client blocks (mpy_32_16-style functions, Levinson, filters).
- Clients request operations instead of instantiating their own multipliers.
- Arbitration is round-robin; every result is returned with a one-hot done and a per-result overflow flag, bit-exact to the ITU basic-ops C model.

Parameters:
- NUM_REQ, 4, number of client ports (2..8).
- PTR_W, 2, width of the round-robin pointer; must be ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-client request; hold until granted.
- op  input  2*NUM_REQ  per-client opcode, client i at [2i+1:2i]:
  - 00 = L_mult
  - 01 = mult
  - 10 = L_mac
  - 11 = L_msu / reserved
- var_a  input  16*NUM_REQ  per-client operand a, client i at [16i+15:16i].
- var_b  input  16*NUM_REQ  per-client operand b.
- acc_c  input  32*NUM_REQ  per-client accumulator, used by L_mac and L_msu.
- gnt  output  NUM_REQ  one-hot grant, combinational.
- done  output  NUM_REQ  one-hot result-valid, registered.
- result  output  32  operation result.
- overflow  output  1  saturation occurred for this result; valid with done.

Behaviour:
- Reset (reset=0, async):
  - Pipeline valid bits, done, result and overflow are cleared to 0.
  - Round-robin pointer is set to 0.
  - gnt is 0 while reset is low.
  - Operations in flight are discarded; no done is ever issued for them.
- Arbitration:
  - gnt is combinational from req and pointer ptr.
  - The first asserted req, searching from index ptr upward with wrap, receives gnt for one cycle.
  - Exactly one grant is issued per cycle when any req is high; no grant when req==0.
  - After a grant to index i, ptr becomes (i+1) mod NUM_REQ. ptr is unchanged when there is no grant.
- Handshake:
  - A client holds req, op and its operands stable until it sees gnt.
  - Operands are sampled on the clock edge that ends the grant cycle.
  - A client may drop req in the cycle after gnt, or keep it high to queue another operation; it is then re-eligible under round-robin.
- Pipeline (fully pipelined, one issue per cycle, no stalls):
  - Stage 1: register op, a, b, c and client id.
  - Stage 2: signed 16x16 product p = a*b.
  - Stage 3: op-specific shift/saturate/add, registered into result, overflow and done.
  - Latency: gnt in cycle N gives done[id]=1 with result in cycle N+3, for exactly one cycle.
  - result and overflow hold their values when done=0.
- Arithmetic (bit-exact to the ITU C model):
  - L_mult: p<<1. If a=b=0x8000, result is 0x7FFFFFFF and overflow=1.
  - mult: (p>>>15) saturated to 16 bits, then sign-extended to 32. If a=b=0x8000, result is 0x00007FFF and overflow=1.
  - L_mac: L_add(c, L_mult(a,b)). Saturate to 0x7FFFFFFF or 0x80000000 on signed overflow. overflow = (L_mult overflow) OR (add overflow).
  - The 33-bit sum is computed internally; no wrap-around is permitted.
- Simultaneous events: new grants, completion of older ops, and ptr updates all occur in the same cycle independently.

Optional Feature:
- Macro: BASIC_OP_MSU_EN.
- Defined: opcode 11 = L_msu, computed as L_sub(c, L_mult(a,b)). Saturation and overflow follow the same rules as L_mac.
- Undefined: opcode 11 is still granted and completes with normal latency, but result=0 and overflow=0. No subtractor is synthesised.

Test Plan:
- Single op: req[0] with L_mult, a=0x4000, b=0x4000. Expect gnt[0] in cycle N, done[0] in N+3, result=0x20000000, overflow=0.
- Saturation corners, each with a=b=0x8000:
  - L_mult gives 0x7FFFFFFF, overflow=1.
  - mult gives 0x00007FFF, overflow=1.
  - mult with a=b=0x4000 gives 0x00002000, overflow=0.
- L_mac: c=0x7FFFFFF0, a=b=0x0100 gives 0x7FFFFFFF, overflow=1. c=0x00000010 with the same operands gives 0x00020010, overflow=0.
- Round-robin: all 4 req held high with distinct ops. Expect grants 0,1,2,3,0,... back-to-back with no gaps; done one-hot in the same order 3 cycles later with matching results.
- Reset mid-operation: drop reset with 3 ops in flight. Expect done, result and overflow to read 0 immediately and no stale done after release. After release with req=4'b1010, the first grant goes to client 1.
- BASIC_OP_MSU_EN: opcode 11 with c=0, a=b=0x4000.
  - Defined: 0xE0000000, overflow=0.
  - Undefined: 0x00000000, overflow=0, done still at N+3.
